// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receiver with make/break decode.
// Presents the scan code of the currently held key on codigo (8'h00 = none).
// Optional feature macro: PS2_PARITY_CHECK_EN (odd parity check on each frame).
//
// Handshake note: code_stb and frame_err are single-cycle, unacknowledged
// pulses; there is no ready path. codigo/key_held are level outputs that only
// change on the clock edge that raises code_stb.
module ps2_scancode_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] codigo,
    output logic       key_held,
    output logic       code_stb,
    output logic       frame_err,
    output logic [1:0] rx_state_dbg,
    output logic [1:0] dec_state_dbg
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {D_IDLE, D_BRK, D_EXT, D_EXTBRK} dec_state_t;

    logic            clk_s1, clk_s2, data_s1, data_s2;
    logic            clk_filt;
    logic [FW-1:0]   flt_cnt;
    logic            fall_edge;
    logic [TW-1:0]   to_cnt;
    logic            timeout;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic            par_ok;
    logic            byte_ok;
    logic            rx_err;
    rx_state_t       rx_state, rx_next;
    dec_state_t      dec_state, dec_next;
    logic [7:0]      codigo_nxt;

    // Two-flop synchronisers; lines idle high so reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Glitch filter: accept a new clock level only after FILTER_LEN cycles of disagreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
        end else if (clk_s2 == clk_filt) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_s2;
            flt_cnt  <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    // The sample point is the cycle on which the filtered clock is about to fall.
    assign fall_edge = clk_filt & ~clk_s2 & (flt_cnt == FW'(FILTER_LEN - 1));

    // An edge on the expiry cycle keeps the frame alive.
    assign timeout = (rx_state != RX_IDLE) && !fall_edge &&
                     (to_cnt == TW'(TIMEOUT_CYC - 1));

    // Inactivity counter, restarted by every edge and idle outside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (rx_state == RX_IDLE || fall_edge || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Receive datapath: shift data LSB first, count bits, capture parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else if (rx_state == RX_IDLE) begin
            bit_cnt <= '0;
        end else if (fall_edge && rx_state == RX_DATA) begin
            shreg   <= {data_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
        end else if (fall_edge && rx_state == RX_PAR) begin
            par_bit <= data_s2;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^{shreg, par_bit};
`else
    assign par_ok = 1'b1;
`endif

    // Receive FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    // Receive FSM next-state logic.
    always_comb begin
        rx_next = rx_state;
        if (timeout) begin
            rx_next = RX_IDLE;
        end else if (fall_edge) begin
            case (rx_state)
                RX_IDLE: if (!data_s2) rx_next = RX_DATA;
                RX_DATA: if (bit_cnt == 3'd7) rx_next = RX_PAR;
                RX_PAR:  rx_next = RX_STOP;
                RX_STOP: rx_next = RX_IDLE;
                default: rx_next = RX_IDLE;
            endcase
        end
    end

    // Receive FSM outputs: accept or reject at the stop bit, or abort on timeout.
    always_comb begin
        byte_ok = 1'b0;
        rx_err  = timeout;
        if (rx_state == RX_STOP && fall_edge) begin
            byte_ok = data_s2 & par_ok;
            rx_err  = ~(data_s2 & par_ok);
        end
    end

    // Registered strobes, one clock after the stop-bit sample point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            code_stb  <= byte_ok;
            frame_err <= rx_err;
        end
    end

    // Decode FSM state register; advances only on accepted bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          dec_state <= D_IDLE;
        else if (byte_ok) dec_state <= dec_next;
    end

    // Decode FSM next-state logic; keyboard error bytes always resync to idle.
    always_comb begin
        dec_next = D_IDLE;
        if (shreg != 8'h00 && shreg != 8'hFF) begin
            case (dec_state)
                D_IDLE: begin
                    if (shreg == 8'hF0)      dec_next = D_BRK;
                    else if (shreg == 8'hE0) dec_next = D_EXT;
                end
                D_EXT:   if (shreg == 8'hF0) dec_next = D_EXTBRK;
                default: dec_next = D_IDLE;
            endcase
        end
    end

    // Decode FSM output: the held key code after this byte.
    always_comb begin
        codigo_nxt = codigo;
        if (shreg != 8'h00 && shreg != 8'hFF) begin
            case (dec_state)
                D_IDLE: begin
                    if (shreg == 8'hAA)
                        codigo_nxt = 8'h00;
                    else if (shreg != 8'hF0 && shreg != 8'hE0)
                        codigo_nxt = shreg;
                end
                D_BRK:   if (shreg == codigo) codigo_nxt = 8'h00;
                default: codigo_nxt = codigo;
            endcase
        end
    end

    // Held-key register, updated together with code_stb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            codigo   <= 8'h00;
            key_held <= 1'b0;
        end else if (byte_ok) begin
            codigo   <= codigo_nxt;
            key_held <= (codigo_nxt != 8'h00);
        end
    end

    assign rx_state_dbg  = rx_state;
    assign dec_state_dbg = dec_state;

endmodule
